// File: rtl/apo_noc_pkg.sv
// Shared definitions for the circulant NoC node-side blocks.
// K          : width of node numbers and step fields.
// N2         : packet width, one valid bit plus 2*K payload bits.
// NODE_COUNT : nodes in the circulant; legal destinations are 0..NODE_COUNT-1.
// VALID_BIT / DEST_LSB : packet field positions on the router node port.
package apo_noc_pkg;

  localparam int K          = 8;
  localparam int N2         = 2 * K + 1;
  localparam int NODE_COUNT = 196;

  localparam int VALID_BIT  = N2 - 1;
  localparam int DEST_LSB   = 0;

  typedef struct packed {
    logic                  valid;
    logic [N2-2-K:0]       reserved;
    logic [K-1:0]          dest;
  } apo_pkt_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INJECT = 2'd1,
    S_GAP    = 2'd2
  } inj_state_e;

endpackage

// File: rtl/apo_node_injector_if.sv
// Node-side request handshake of the injector.
// req_valid : node has a destination to send.
// req_dest  : destination node number.
// req_ready : injector request FIFO can accept.
// master modport = computing node, slave modport = injector.
interface apo_node_injector_if;
  import apo_noc_pkg::*;

  logic         req_valid;
  logic [K-1:0] req_dest;
  logic         req_ready;

  modport master (output req_valid, output req_dest, input req_ready);
  modport slave  (input req_valid, input req_dest, output req_ready);

endinterface

// File: rtl/apo_req_fifo.sv
// Synchronous request FIFO for the node injector.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data,
// full, empty, level (entries queued). DEPTH must be a power of two >= 2.
// Push while full and pop while empty are ignored.
module apo_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/apo_node_injector.sv
// Node-side network interface for a circulant router's node port.
// Transmit: queues node destination requests and injects each as a one-cycle
// packet {valid, 0..., dest} on to_router, deferring while link_busy is high
// and forcing GAP_CYCLES idle cycles after every injection.
// Receive: rx_pulse is a registered copy of from_router_data.
// Ports: clk, rst_n (sync, active-low), router_name, req (request handshake
// interface, slave side), link_busy, to_router, from_router_data, rx_pulse,
// err_bad_dest, fifo_level.
// Optional macro APO_NODE_INJECTOR_STATS_EN adds tx_count, rx_count (16-bit
// saturating) and self_rx (receive pulse while the last injected destination
// was this node).
module apo_node_injector
  import apo_noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [K-1:0]                  router_name,
  apo_node_injector_if.slave            req,
  input  logic                          link_busy,
  output logic [N2-1:0]                 to_router,
  input  logic                          from_router_data,
  output logic                          rx_pulse,
  output logic                          err_bad_dest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef APO_NODE_INJECTOR_STATS_EN
  ,
  output logic [15:0]                   tx_count,
  output logic [15:0]                   rx_count,
  output logic                          self_rx
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  inj_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [N2-1:0] to_router_q, to_router_d;
  logic          rx_pulse_q;
  logic          err_bad_dest_q, err_bad_dest_d;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push, dest_ok, accept;
  logic [K-1:0]  fifo_head;
  logic          try_inject;

  // Ready reflects the pre-pop state: a full FIFO stalls even if it pops.
  assign req.req_ready = !fifo_full;
  assign accept        = req.req_valid && !fifo_full;
  assign dest_ok       = (32'(req.req_dest) < NODE_COUNT);
  assign fifo_push     = accept && dest_ok;
  assign err_bad_dest_d = accept && !dest_ok;

  apo_req_fifo #(
    .WIDTH (K),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (req.req_dest),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // try_inject marks the edges that take the idle decision: IDLE itself, the
  // INJECT edge when no gap is configured, and the last GAP edge. This gives
  // exactly GAP_CYCLES zero cycles between consecutive packets.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    to_router_d = '0;
    fifo_pop    = 1'b0;
    try_inject  = 1'b0;
    unique case (state_q)
      S_IDLE:   try_inject = 1'b1;
      S_INJECT: begin
        if (GAP_CYCLES == 0) begin
          try_inject = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) try_inject = 1'b1;
        else             gap_d = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (try_inject) begin
      if (!fifo_empty && !link_busy) begin
        state_d                    = S_INJECT;
        fifo_pop                   = 1'b1;
        to_router_d[VALID_BIT]     = 1'b1;
        to_router_d[DEST_LSB +: K] = fifo_head;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      gap_q          <= '0;
      to_router_q    <= '0;
      rx_pulse_q     <= 1'b0;
      err_bad_dest_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      to_router_q    <= to_router_d;
      rx_pulse_q     <= from_router_data;
      err_bad_dest_q <= err_bad_dest_d;
    end
  end

  assign to_router    = to_router_q;
  assign rx_pulse     = rx_pulse_q;
  assign err_bad_dest = err_bad_dest_q;

`ifdef APO_NODE_INJECTOR_STATS_EN
  logic [15:0]  tx_count_q, tx_count_d;
  logic [15:0]  rx_count_q, rx_count_d;
  logic         self_rx_q, self_rx_d;
  logic         last_vld_q, last_vld_d;
  logic [K-1:0] last_dest_q, last_dest_d;

  always_comb begin
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    last_vld_d  = last_vld_q;
    last_dest_d = last_dest_q;
    if (fifo_pop && tx_count_q != 16'hFFFF) tx_count_d = tx_count_q + 16'd1;
    if (from_router_data && rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
    if (fifo_pop) begin
      last_vld_d  = 1'b1;
      last_dest_d = fifo_head;
    end
    self_rx_d = from_router_data && last_vld_q && (last_dest_q == router_name);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
      self_rx_q  <= 1'b0;
      last_vld_q <= 1'b0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      self_rx_q  <= self_rx_d;
      last_vld_q <= last_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    last_dest_q <= last_dest_d;
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign self_rx  = self_rx_q;
`else
  // router_name only feeds the statistics logic.
  logic unused_router_name;
  assign unused_router_name = ^router_name;
`endif

endmodule

// File: doc/apo_node_injector.md
Name: apo_node_injector

Overview:
- Network-interface block between a computing node and its circulant router's node (free) port.
- Transmit side:
  - Accepts destination requests from the node over a valid/ready handshake.
  - Buffers them in a small FIFO.
  - Emits each as a one-cycle packet {valid, destination} on the router's node input.
  - Defers injection while transit traffic is present.
- Receive side: registers the router's arrival strobe back to the node.

Parameters:
- K, 8, width of node numbers and step fields.
- N2, 17, packet width: 1 valid bit plus 2*K payload bits.
- NODE_COUNT, 196, number of nodes in the circulant; legal destinations are 0..NODE_COUNT-1.
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- GAP_CYCLES, 2, idle cycles forced after each injection; 0 allows back-to-back injection.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- router_name  in  K  this node's number, static; used only for statistics and self-check.
- req_valid  in  1  node has a destination to send.
- req_dest  in  K  destination node number.
- req_ready  out  1  request FIFO can accept.
- link_busy  in  1  OR of the valid bits of the router's four inter-router inputs this cycle.
- to_router  out  N2  packet to the router node port; bit N2-1 is valid, bits K-1:0 are the destination, all other bits are 0.
- from_router_data  in  1  router arrival strobe.
- rx_pulse  out  1  registered copy of from_router_data.
- err_bad_dest  out  1  one-cycle pulse when an out-of-range destination is dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following are cleared at that edge regardless of state:
  - to_router=0, rx_pulse=0, err_bad_dest=0.
  - FIFO emptied (fifo_level=0).
  - FSM set to IDLE, gap counter=0.
- req_ready:
  - Combinational: req_ready = !full, evaluated before any same-cycle pop.
  - No bypass when full: a full FIFO stalls requests even if a pop occurs that cycle.
- Accept and drop:
  - Accept occurs on an edge where req_valid && req_ready.
  - If req_dest < NODE_COUNT, the destination is pushed.
  - Otherwise the request is consumed but not queued, and err_bad_dest=1 for the following cycle only.
- FSM states: IDLE, INJECT, GAP.
  - IDLE -> INJECT on an edge where FIFO is non-empty && link_busy=0. At that edge:
    - FIFO head is popped.
    - to_router <= {1'b1, {(N2-1-K){1'b0}}, head}.
  - IDLE stays IDLE while FIFO is empty or link_busy=1. Deferral is unbounded; no packet is lost.
  - INJECT lasts exactly one cycle; to_router returns to 0 at the next edge.
    - If GAP_CYCLES=0, this edge applies the IDLE decision directly, so back-to-back valid packets are possible.
    - Otherwise the FSM enters GAP with counter=GAP_CYCLES-1.
  - GAP decrements each edge and returns to IDLE when the counter reaches 0. to_router=0 throughout GAP.
- Latency: a request accepted at edge t, with the FIFO previously empty and link_busy=0, drives to_router valid during the cycle after edge t+1, for exactly one cycle.
- Ordering: strict FIFO. Simultaneous push and pop in one cycle is legal and leaves fifo_level unchanged.
- Receive side: rx_pulse <= from_router_data every edge, giving one cycle of latency. Pulses are not merged or stretched.
- Self-addressed destination (req_dest == router_name) is legal and injected normally.
- Reset mid-injection: a packet in INJECT at the reset edge is withdrawn (to_router=0 after that edge); queued entries are discarded.

Optional Feature:
- Macro: APO_NODE_INJECTOR_STATS_EN.
- Defined:
  - Adds outputs tx_count[15:0] and rx_count[15:0], both saturating at 16'hFFFF and cleared by reset.
  - tx_count increments on each INJECT entry.
  - rx_count increments on each cycle with from_router_data=1.
  - Adds self_rx out 1: pulses together with rx_pulse when the most recent injected destination equals router_name.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package apo_noc_pkg holds:
  - Constants K, N2, NODE_COUNT.
  - Packet field positions: VALID_BIT=N2-1, DEST_LSB=0.
  - A packet typedef (valid, reserved, dest).
  - FSM state enum.
- Sub-module apo_req_fifo: synchronous FIFO, parameters WIDTH/DEPTH, with push/pop/full/empty/level. The injector FSM and the receive register stay in the top.

Test Plan:
1. Reset then idle: rst_n=0 for 2 edges, then release with no requests.
   -> to_router=0, req_ready=1, fifo_level=0, rx_pulse=0 throughout.
2. Single request: req_dest=37 accepted at edge t, link_busy=0.
   -> to_router=17'h10025 for exactly one cycle after edge t+1, then 0 for 2 GAP cycles.
3. Burst of 6 requests (10..15), FIFO_DEPTH=4, link_busy=0.
   -> req_ready drops after 4 queued; packets 10..15 emerge in order, spaced 3 cycles apart; no loss.
4. Deferral: 1 request queued with link_busy=1 for 5 cycles, then 0.
   -> to_router stays 0 for those 5 cycles, then valid for 1 cycle with the correct destination.
5. Bad destination: req_dest=200 with NODE_COUNT=196.
   -> Handshake completes, err_bad_dest pulses 1 cycle, fifo_level stays 0, no packet emitted.
6. Reset mid-operation: assert rst_n=0 during INJECT with 3 entries queued.
   -> After the reset edge, to_router=0 and fifo_level=0; no further packets appear.
   -> With the stats macro defined, tx_count=0 after reset.
